f1_start_seq: RTL and testbench

//  Parametrised F1 start-light sequencer: lights N_LIGHTS LEDs one per TICKS_PER_LIGHT ticks,

---
 rtl/f1_start_seq_pkg.sv | 27 ++
 rtl/f1_start_seq_if.sv | 33 +++
 rtl/f1_start_seq_react_timer.sv | 55 +++++
 rtl/f1_start_seq.sv | 177 +++++++++++++++++
 tb/tb_f1_start_seq.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/f1_start_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : f1_pkg
//  Brief    : Shared types and helpers for the F1 start-light sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package f1_pkg;

    // Widest reaction-time counter the helper below can describe
    localparam int unsigned c_RT_W_MAX = 32;

    // Sequencer states; IDLE must stay the reset encoding
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COUNT   = 3'd1,
        DELAY   = 3'd2,
        MEASURE = 3'd3,
        FAULT   = 3'd4
    } f1_state_t;

    // All-ones "no response" code for a reaction counter of the given width
    function automatic logic [c_RT_W_MAX-1:0] rt_noresp(input int unsigned width);
        return {c_RT_W_MAX{1'b1}} >> (c_RT_W_MAX - width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/f1_start_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : f1_start_seq_if
//  Brief    : Timebase, driver and light signals of the start sequencer.
//             slave = sequencer side, master = surrounding logic side.
//  Revision : 1.0 - initial release
// ============================================================================
interface f1_start_seq_if #(
    parameter int N_LIGHTS = 10,
    parameter int RT_W     = 10
);
    logic                tick;
    logic                trigger;
    logic                time_out;
    logic                react;
    logic                en_lfsr;
    logic                start_delay;
    logic [N_LIGHTS-1:0] ledr;
    logic [RT_W-1:0]     react_time;
    logic                rt_valid;
    logic                jump_start;

    modport slave (
        input  tick, trigger, time_out, react,
        output en_lfsr, start_delay, ledr, react_time, rt_valid, jump_start
    );

    modport master (
        output tick, trigger, time_out, react,
        input  en_lfsr, start_delay, ledr, react_time, rt_valid, jump_start
    );
endinterface
`default_nettype wire

// File: rtl/f1_start_seq_react_timer.sv
`default_nettype none
// ============================================================================
//  Module   : f1_react_timer
//  Brief    : Saturating reaction-time tick counter with clear, a capture
//             register holding the last result, and a saturation flag.
//  Revision : 1.0 - initial release
// ============================================================================
module f1_react_timer
    import f1_pkg::*;
#(
    parameter int RT_W = 10
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            i_clear,
    input  wire logic            i_inc,
    input  wire logic            i_capture,
    output logic [RT_W-1:0]      o_captured,
    output logic                 o_sat
);

    localparam logic [RT_W-1:0] c_ALL_ONES = RT_W'(rt_noresp(RT_W));

    logic [RT_W-1:0] r_cnt;
    logic [RT_W-1:0] r_captured;
    logic            w_sat;

    // Saturated counter doubles as the "no response" indication
    assign w_sat = (r_cnt == c_ALL_ONES);

    // Count ticks, stopping at all-ones; clear wins over increment
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_inc && !w_sat) begin
            r_cnt <= r_cnt + RT_W'(1);
        end
    end

    // Capture the pre-increment count so a same-cycle tick is not included
    always_ff @(posedge clk) begin
        if (rst) begin
            r_captured <= '0;
        end else if (i_capture) begin
            r_captured <= r_cnt;
        end
    end

    assign o_captured = r_captured;
    assign o_sat      = w_sat;

endmodule
`default_nettype wire

// File: rtl/f1_start_seq.sv
`default_nettype none
// ============================================================================
//  Module   : f1_start_seq
//  Brief    : F1 start-light sequencer. Lights the LEDs one by one, hands off
//             to the external random delay, measures reaction time at
//             lights-out and latches a jump-start fault on an early press.
//  Revision : 1.0 - initial release
// ============================================================================
module f1_start_seq
    import f1_pkg::*;
#(
    parameter int N_LIGHTS        = 10,
    parameter int TICKS_PER_LIGHT = 1,
    parameter int RT_W            = 10
) (
    input  wire logic      sysclk,
    input  wire logic      rst,
    f1_start_seq_if.slave  bus
);

    localparam int                     c_IDX_W     = $clog2(N_LIGHTS + 1);
    localparam int                     c_TCNT_W    = $clog2(TICKS_PER_LIGHT + 1);
    localparam logic [c_IDX_W-1:0]     c_IDX_LAST  = c_IDX_W'(N_LIGHTS);
    localparam logic [c_TCNT_W-1:0]    c_TICK_LAST = c_TCNT_W'(TICKS_PER_LIGHT - 1);
    localparam logic [N_LIGHTS-1:0]    c_LEDS_ON   = {N_LIGHTS{1'b1}};

    f1_state_t             r_state;
    f1_state_t             w_state_next;
    logic [c_IDX_W-1:0]    r_light_idx;
    logic [c_TCNT_W-1:0]   r_tick_cnt;
    logic [N_LIGHTS-1:0]   r_ledr;
    logic                  r_start_delay;
    logic                  r_rt_valid;
    logic                  r_jump_start;
    logic [N_LIGHTS-1:0]   w_light_mask;
    logic                  w_all_lit;
    logic                  w_timeout_take;
    logic                  w_rt_inc;
    logic                  w_rt_capture;
    logic                  w_rt_sat;
    logic [RT_W-1:0]       w_rt_captured;

    assign w_all_lit    = (r_light_idx == c_IDX_LAST);
    assign w_light_mask = N_LIGHTS'(1) << r_light_idx;

    // time_out is ignored during the start_delay cycle and loses to react
    assign w_timeout_take = (r_state == DELAY) && bus.time_out
                            && !r_start_delay && !bus.react;
    assign w_rt_inc       = (r_state == MEASURE) && bus.tick;
    assign w_rt_capture   = (r_state == MEASURE) && (bus.react || w_rt_sat);

    // State register
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; react takes priority over every other event
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.trigger) begin
                    w_state_next = COUNT;
                end
            end
            COUNT: begin
                if (bus.react) begin
                    w_state_next = FAULT;
                end else if (w_all_lit) begin
                    w_state_next = DELAY;
                end
            end
            DELAY: begin
                if (bus.react) begin
                    w_state_next = FAULT;
                end else if (w_timeout_take) begin
                    w_state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (bus.react || w_rt_sat) begin
                    w_state_next = IDLE;
                end
            end
            FAULT: begin
                if (bus.trigger) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Light shifter, tick prescale, fault flag and single-cycle pulses
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_light_idx   <= '0;
            r_tick_cnt    <= '0;
            r_ledr        <= '0;
            r_start_delay <= 1'b0;
            r_rt_valid    <= 1'b0;
            r_jump_start  <= 1'b0;
        end else begin
            r_start_delay <= (w_state_next == DELAY) && (r_state != DELAY);
            r_rt_valid    <= w_rt_capture;
            case (r_state)
                IDLE: begin
                    r_ledr      <= '0;
                    r_light_idx <= '0;
                    r_tick_cnt  <= '0;
                end
                COUNT: begin
                    if (bus.react) begin
                        r_ledr       <= c_LEDS_ON;
                        r_jump_start <= 1'b1;
                    end else if (bus.tick && !w_all_lit) begin
                        if (r_tick_cnt == c_TICK_LAST) begin
                            r_ledr      <= r_ledr | w_light_mask;
                            r_light_idx <= r_light_idx + c_IDX_W'(1);
                            r_tick_cnt  <= '0;
                        end else begin
                            r_tick_cnt  <= r_tick_cnt + c_TCNT_W'(1);
                        end
                    end
                end
                DELAY: begin
                    if (bus.react) begin
                        r_ledr       <= c_LEDS_ON;
                        r_jump_start <= 1'b1;
                    end else if (w_timeout_take) begin
                        r_ledr <= '0;
                    end
                end
                MEASURE: begin
                end
                FAULT: begin
                    if (bus.trigger) begin
                        r_jump_start <= 1'b0;
                        r_ledr       <= '0;
                    end else if (bus.tick) begin
                        r_ledr <= ~r_ledr;
                    end
                end
                default: begin
                    r_ledr <= '0;
                end
            endcase
        end
    end

    f1_react_timer #(
        .RT_W (RT_W)
    ) u_react_timer (
        .clk        (sysclk),
        .rst        (rst),
        .i_clear    (w_timeout_take),
        .i_inc      (w_rt_inc),
        .i_capture  (w_rt_capture),
        .o_captured (w_rt_captured),
        .o_sat      (w_rt_sat)
    );

    assign bus.en_lfsr     = (r_state == IDLE);
    assign bus.start_delay = r_start_delay;
    assign bus.ledr        = r_ledr;
    assign bus.react_time  = w_rt_captured;
    assign bus.rt_valid    = r_rt_valid;
    assign bus.jump_start  = r_jump_start;

endmodule
`default_nettype wire

// File: tb/tb_f1_start_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_f1_start_seq
//  Brief    : Directed bench for f1_start_seq with N_LIGHTS=5,
//             TICKS_PER_LIGHT=2, RT_W=4. Light patterns and reaction results
//             are queued as stimulus is applied and checked as they appear.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_f1_start_seq;

    localparam int N_LIGHTS        = 5;
    localparam int TICKS_PER_LIGHT = 2;
    localparam int RT_W            = 4;

    logic sysclk = 1'b0;
    logic rst    = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;

    logic [N_LIGHTS-1:0] exp_ledr_q[$];
    logic [RT_W-1:0]     exp_rt_q[$];
    logic [N_LIGHTS-1:0] prev_ledr;
    logic                mon_en = 1'b0;

    f1_start_seq_if #(.N_LIGHTS(N_LIGHTS), .RT_W(RT_W)) bus ();

    f1_start_seq #(
        .N_LIGHTS        (N_LIGHTS),
        .TICKS_PER_LIGHT (TICKS_PER_LIGHT),
        .RT_W            (RT_W)
    ) dut (
        .sysclk (sysclk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle 1 time unit
    task automatic cyc();
        @(posedge sysclk);
        #1;
    endtask

    // One tick strobe followed by three quiet cycles
    task automatic tick_period();
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        cyc();
        cyc();
        cyc();
    endtask

    task automatic push_lights(input int n);
        logic [N_LIGHTS-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) begin
            v[i] = 1'b1;
            exp_ledr_q.push_back(v);
        end
    endtask

    // Observe light changes and reaction results against the scoreboard
    always @(negedge sysclk) begin
        if (mon_en) begin
            if (bus.ledr !== prev_ledr) begin
                check("ledr_change_expected", 32'(exp_ledr_q.size() != 0), 32'd1);
                if (exp_ledr_q.size() != 0)
                    check("ledr_pattern", 32'(bus.ledr), 32'(exp_ledr_q.pop_front()));
                prev_ledr = bus.ledr;
            end
            if (bus.rt_valid === 1'b1) begin
                check("rt_event_expected", 32'(exp_rt_q.size() != 0), 32'd1);
                if (exp_rt_q.size() != 0)
                    check("react_time", 32'(bus.react_time), 32'(exp_rt_q.pop_front()));
            end
        end
    end

    initial begin
        bus.tick     = 1'b0;
        bus.trigger  = 1'b0;
        bus.time_out = 1'b0;
        bus.react    = 1'b0;

        // ---- reset state ----
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        check("rst_ledr",        32'(bus.ledr),        32'd0);
        check("rst_en_lfsr",     32'(bus.en_lfsr),     32'd1);
        check("rst_start_delay", 32'(bus.start_delay), 32'd0);
        check("rst_rt_valid",    32'(bus.rt_valid),    32'd0);
        check("rst_jump_start",  32'(bus.jump_start),  32'd0);
        check("rst_react_time",  32'(bus.react_time),  32'd0);
        prev_ledr = '0;
        mon_en    = 1'b1;

        // ---- reset mid-COUNT with three lights lit ----
        bus.trigger = 1'b1;
        cyc();
        bus.trigger = 1'b0;
        push_lights(3);
        for (int i = 0; i < 6; i++) tick_period();
        check("midrst_pre_ledr", 32'(bus.ledr), 32'h07);
        exp_ledr_q.push_back('0);
        rst = 1'b1;
        cyc();
        check("midrst_ledr",        32'(bus.ledr),        32'd0);
        check("midrst_en_lfsr",     32'(bus.en_lfsr),     32'd1);
        check("midrst_start_delay", 32'(bus.start_delay), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick_period();
        check("midrst_idle_ledr",   32'(bus.ledr),        32'd0);
        check("midrst_idle_sd",     32'(bus.start_delay), 32'd0);

        // ---- full sequence, time_out 20 cycles later, react after 3 ticks ----
        bus.trigger = 1'b1;
        cyc();
        bus.trigger = 1'b0;
        check("count_en_lfsr", 32'(bus.en_lfsr), 32'd0);
        push_lights(N_LIGHTS);
        for (int i = 0; i < 9; i++) tick_period();
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        check("all_lit",          32'(bus.ledr),        32'h1F);
        check("sd_before",        32'(bus.start_delay), 32'd0);
        cyc();
        check("sd_pulse",         32'(bus.start_delay), 32'd1);
        cyc();
        check("sd_after",         32'(bus.start_delay), 32'd0);
        for (int i = 0; i < 18; i++) cyc();
        check("delay_hold_ledr",  32'(bus.ledr),        32'h1F);
        exp_ledr_q.push_back('0);
        bus.time_out = 1'b1;
        cyc();
        bus.time_out = 1'b0;
        check("lights_out",       32'(bus.ledr),        32'd0);
        check("measure_en_lfsr",  32'(bus.en_lfsr),     32'd0);
        for (int i = 0; i < 3; i++) tick_period();
        exp_rt_q.push_back(RT_W'(3));
        bus.react = 1'b1;
        cyc();
        bus.react = 1'b0;
        check("rt_valid_pulse",   32'(bus.rt_valid),    32'd1);
        check("rt_value",         32'(bus.react_time),  32'd3);
        check("rt_idle_en_lfsr",  32'(bus.en_lfsr),     32'd1);
        cyc();
        check("rt_valid_end",     32'(bus.rt_valid),    32'd0);

        // ---- jump start while three lights lit ----
        bus.trigger = 1'b1;
        cyc();
        bus.trigger = 1'b0;
        push_lights(3);
        for (int i = 0; i < 6; i++) tick_period();
        exp_ledr_q.push_back(5'h1F);
        bus.react = 1'b1;
        cyc();
        bus.react = 1'b0;
        check("js_flag",          32'(bus.jump_start),  32'd1);
        check("js_ledr_on",       32'(bus.ledr),        32'h1F);
        check("js_en_lfsr",       32'(bus.en_lfsr),     32'd0);
        exp_ledr_q.push_back(5'h00);
        exp_ledr_q.push_back(5'h1F);
        tick_period();
        check("js_toggle_off",    32'(bus.ledr),        32'h00);
        tick_period();
        check("js_toggle_on",     32'(bus.ledr),        32'h1F);
        bus.react = 1'b1;
        cyc();
        bus.react = 1'b0;
        check("js_react_ignored", 32'(bus.jump_start),  32'd1);
        exp_ledr_q.push_back('0);
        bus.trigger = 1'b1;
        cyc();
        bus.trigger = 1'b0;
        check("js_clear_flag",    32'(bus.jump_start),  32'd0);
        check("js_clear_ledr",    32'(bus.ledr),        32'd0);
        check("js_clear_en_lfsr", 32'(bus.en_lfsr),     32'd1);

        // ---- react and time_out in the same DELAY cycle ----
        bus.trigger = 1'b1;
        cyc();
        bus.trigger = 1'b0;
        push_lights(N_LIGHTS);
        for (int i = 0; i < 10; i++) tick_period();
        bus.react    = 1'b1;
        bus.time_out = 1'b1;
        cyc();
        bus.react    = 1'b0;
        bus.time_out = 1'b0;
        check("tie_jump_start",   32'(bus.jump_start),  32'd1);
        check("tie_rt_valid",     32'(bus.rt_valid),    32'd0);
        check("tie_ledr",         32'(bus.ledr),        32'h1F);
        cyc();
        check("tie_rt_valid_2",   32'(bus.rt_valid),    32'd0);
        exp_ledr_q.push_back('0);
        bus.trigger = 1'b1;
        cyc();
        bus.trigger = 1'b0;
        check("tie_back_idle",    32'(bus.en_lfsr),     32'd1);

        // ---- no response: counter saturates at all-ones ----
        bus.trigger = 1'b1;
        cyc();
        bus.trigger = 1'b0;
        push_lights(N_LIGHTS);
        for (int i = 0; i < 10; i++) tick_period();
        exp_ledr_q.push_back('0);
        bus.time_out = 1'b1;
        cyc();
        bus.time_out = 1'b0;
        exp_rt_q.push_back({RT_W{1'b1}});
        for (int i = 0; i < 14; i++) tick_period();
        check("noresp_still_meas", 32'(bus.en_lfsr),    32'd0);
        tick_period();
        check("noresp_rt",        32'(bus.react_time),  32'hF);
        check("noresp_idle",      32'(bus.en_lfsr),     32'd1);
        check("noresp_rt_valid",  32'(bus.rt_valid),    32'd0);

        // ---- every queued expectation must have been consumed ----
        cyc();
        check("ledr_queue_empty", 32'(exp_ledr_q.size()), 32'd0);
        check("rt_queue_empty",   32'(exp_rt_q.size()),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
